chunk_dispatcher: RTL and testbench

CHUNK_DISPATCHER -- requirements
Module: chunk_dispatcher

---
 rtl/chunk_dispatch_pkg.sv | 21 ++
 rtl/chunk_dispatcher_free_pool.sv | 47 ++++
 rtl/chunk_dispatcher.sv | 143 ++++++++++++++
 tb/tb_chunk_dispatcher.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chunk_dispatch_pkg.sv
// rtl/chunk_dispatch_pkg.sv - default widths, FSM state and descriptor type for chunk_dispatcher
package chunk_dispatch_pkg;

  localparam int DEF_VCHANNELBITS = 3;
  localparam int DEF_SLAVEBITS    = 2;
  localparam int DEF_CHUNKBITS    = 9;
  localparam int DEF_INDEXBITS    = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  // Descriptor as popped from the index FIFO (default widths).
  typedef struct packed {
    logic [DEF_CHUNKBITS-1:0] id;
    logic [DEF_INDEXBITS-1:0] start;
    logic [DEF_INDEXBITS-1:0] stop;
  } chunk_desc_t;

endpackage

// File: rtl/chunk_dispatcher_free_pool.sv
// rtl/chunk_dispatcher_free_pool.sv - busy bitmap with circular first-free search and double-free detect
module free_pool #(
  parameter int IDXBITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc,
  input  logic                      free_valid,
  input  logic [IDXBITS-1:0]        free_idx,
  input  logic [IDXBITS-1:0]        start_idx,
  output logic [IDXBITS-1:0]        grant_idx,
  output logic                      any_free,
  output logic [(2**IDXBITS)-1:0]   busy,
  output logic                      double_free
);

  localparam int N = 2**IDXBITS;

  logic found;

  // First free entry at or after start_idx, wrapping around the pool.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && !busy[start_idx + IDXBITS'(i)]) begin
        found     = 1'b1;
        grant_idx = start_idx + IDXBITS'(i);
      end
    end
  end

  assign any_free    = ~&busy;
  assign double_free = free_valid & ~busy[free_idx];

  // Free and allocate may land in the same edge; the grant comes from the
  // pre-edge bitmap so it never collides with a still-busy entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (free_valid) busy[free_idx]  <= 1'b0;
      if (alloc)      busy[grant_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/chunk_dispatcher.sv
// rtl/chunk_dispatcher.sv - allocates a slave and VC per chunk descriptor; CHUNK_DISPATCH_RR_EN selects round-robin slaves
module chunk_dispatcher
  import chunk_dispatch_pkg::*;
#(
  parameter int VCHANNELBITS = DEF_VCHANNELBITS,
  parameter int SLAVEBITS    = DEF_SLAVEBITS,
  parameter int CHUNKBITS    = DEF_CHUNKBITS,
  parameter int INDEXBITS    = DEF_INDEXBITS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           chunk_valid,
  output logic                           chunk_ready,
  input  logic [CHUNKBITS-1:0]           chunk_id,
  input  logic [INDEXBITS-1:0]           chunk_start,
  input  logic [INDEXBITS-1:0]           chunk_end,
  output logic                           disp_valid,
  input  logic                           disp_ready,
  output logic [SLAVEBITS-1:0]           disp_slave,
  output logic [VCHANNELBITS-1:0]        disp_vc,
  output logic [CHUNKBITS-1:0]           disp_id,
  output logic [INDEXBITS-1:0]           disp_start,
  output logic [INDEXBITS-1:0]           disp_end,
  input  logic                           done_valid,
  input  logic [SLAVEBITS-1:0]           done_slave,
  input  logic [VCHANNELBITS-1:0]        done_vc,
  output logic [(2**SLAVEBITS)-1:0]      slave_busy,
  output logic [(2**VCHANNELBITS)-1:0]   vc_busy,
  output logic [VCHANNELBITS:0]          in_flight,
  output logic                           err_double_free
);

  localparam int IFW = VCHANNELBITS + 1;

  state_t                  state, state_next;
  logic [SLAVEBITS-1:0]    slave_grant, slave_start;
  logic [VCHANNELBITS-1:0] vc_grant;
  logic                    slave_any, vc_any;
  logic                    slave_dbl, vc_dbl;
  logic                    vc_freed;

  free_pool #(.IDXBITS(SLAVEBITS)) u_slave_pool (
    .clk         (clk),
    .rst         (rst),
    .alloc       (chunk_ready),
    .free_valid  (done_valid),
    .free_idx    (done_slave),
    .start_idx   (slave_start),
    .grant_idx   (slave_grant),
    .any_free    (slave_any),
    .busy        (slave_busy),
    .double_free (slave_dbl)
  );

  free_pool #(.IDXBITS(VCHANNELBITS)) u_vc_pool (
    .clk         (clk),
    .rst         (rst),
    .alloc       (chunk_ready),
    .free_valid  (done_valid),
    .free_idx    (done_vc),
    .start_idx   ('0),
    .grant_idx   (vc_grant),
    .any_free    (vc_any),
    .busy        (vc_busy),
    .double_free (vc_dbl)
  );

`ifdef CHUNK_DISPATCH_RR_EN
  logic [SLAVEBITS-1:0] last_granted;

  // Remember the most recently granted slave so the next search starts past it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             last_granted <= '0;
    else if (chunk_ready) last_granted <= slave_grant;
  end

  assign slave_start = last_granted + SLAVEBITS'(1);
`else
  assign slave_start = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next state: accept a descriptor, then hold until the slave side takes it.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (chunk_ready) state_next = ST_ISSUE;
      ST_ISSUE: if (disp_ready)  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs: pop only when both a slave and a VC are available; rst gates the pop directly.
  always_comb begin
    chunk_ready = rst & (state == ST_IDLE) & chunk_valid & slave_any & vc_any;
    disp_valid  = (state == ST_ISSUE);
  end

  // Capture the descriptor and its allocation; held stable through ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_slave <= '0;
      disp_vc    <= '0;
      disp_id    <= '0;
      disp_start <= '0;
      disp_end   <= '0;
    end else if (chunk_ready) begin
      disp_slave <= slave_grant;
      disp_vc    <= vc_grant;
      disp_id    <= chunk_id;
      disp_start <= chunk_start;
      disp_end   <= chunk_end;
    end
  end

  // A completion naming an idle VC frees nothing, so it must not decrement.
  assign vc_freed = done_valid & ~vc_dbl;

  // Track popcount(vc_busy) incrementally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flight <= '0;
    end else begin
      case ({chunk_ready, vc_freed})
        2'b10:   in_flight <= in_flight + IFW'(1);
        2'b01:   in_flight <= in_flight - IFW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  // Sticky error for a completion that names an unallocated slave or VC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      err_double_free <= 1'b0;
    else if (slave_dbl | vc_dbl)   err_double_free <= 1'b1;
  end

endmodule

// File: tb/tb_chunk_dispatcher.sv
// tb/tb_chunk_dispatcher.sv - directed self-checking bench for chunk_dispatcher
module tb_chunk_dispatcher;

  logic        clk;
  logic        rst;
  logic        chunk_valid;
  logic        chunk_ready;
  logic [8:0]  chunk_id;
  logic [31:0] chunk_start;
  logic [31:0] chunk_end;
  logic        disp_valid;
  logic        disp_ready;
  logic [1:0]  disp_slave;
  logic [2:0]  disp_vc;
  logic [8:0]  disp_id;
  logic [31:0] disp_start;
  logic [31:0] disp_end;
  logic        done_valid;
  logic [1:0]  done_slave;
  logic [2:0]  done_vc;
  logic [3:0]  slave_busy;
  logic [7:0]  vc_busy;
  logic [3:0]  in_flight;
  logic        err_double_free;

  int errors = 0;
  int checks = 0;

  chunk_dispatcher dut (
    .clk             (clk),
    .rst             (rst),
    .chunk_valid     (chunk_valid),
    .chunk_ready     (chunk_ready),
    .chunk_id        (chunk_id),
    .chunk_start     (chunk_start),
    .chunk_end       (chunk_end),
    .disp_valid      (disp_valid),
    .disp_ready      (disp_ready),
    .disp_slave      (disp_slave),
    .disp_vc         (disp_vc),
    .disp_id         (disp_id),
    .disp_start      (disp_start),
    .disp_end        (disp_end),
    .done_valid      (done_valid),
    .done_slave      (done_slave),
    .done_vc         (done_vc),
    .slave_busy      (slave_busy),
    .vc_busy         (vc_busy),
    .in_flight       (in_flight),
    .err_double_free (err_double_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one descriptor right after a rising edge; waited = negedges until
  // chunk_ready was seen (-1 on timeout). Returns just after the accepting edge.
  task automatic offer(input int id, output int waited);
    @(posedge clk);
    #1;
    chunk_valid = 1'b1;
    chunk_id    = 9'(id);
    chunk_start = 32'(id * 100);
    chunk_end   = 32'(id * 100 + 7);
    waited      = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (chunk_ready) begin
        waited = i;
        break;
      end
    end
    if (waited > 0) begin
      @(posedge clk);
      #1;
    end
    chunk_valid = 1'b0;
  endtask

  // One-cycle completion pulse issued from a negedge.
  task automatic done_pulse(input int s, input int v);
    done_valid = 1'b1;
    done_slave = 2'(s);
    done_vc    = 3'(v);
    @(posedge clk);
    #1;
    done_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    chunk_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({chunk_ready, disp_valid, err_double_free} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got ready/valid/err=%b want 000", {chunk_ready, disp_valid, err_double_free});
    end
    checks++;
    if ({slave_busy, vc_busy, in_flight} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_pools: got slave=%h vc=%h inflight=%0d want 0", slave_busy, vc_busy, in_flight);
    end
    checks++;
    if ({disp_slave, disp_vc, disp_id, disp_start, disp_end} !== 78'd0) begin
      errors++;
      $display("FAIL reset_fields: got id=%0d start=%0d end=%0d want 0", disp_id, disp_start, disp_end);
    end
    chunk_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill;
    int w;
    disp_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      offer(k, w);
      checks++;
      if (w < 0) begin
        errors++;
        $display("FAIL fill_accept_%0d: got timeout want accept", k);
      end
      @(negedge clk);
      checks++;
      if ({disp_valid, disp_slave, disp_vc, disp_id} !== {1'b1, 2'(k - 1), 3'(k - 1), 9'(k)}) begin
        errors++;
        $display("FAIL fill_disp_%0d: got v=%b s=%0d vc=%0d id=%0d want v=1 s=%0d vc=%0d id=%0d",
                 k, disp_valid, disp_slave, disp_vc, disp_id, k - 1, k - 1, k);
      end
      checks++;
      if ({disp_start, disp_end} !== {32'(k * 100), 32'(k * 100 + 7)}) begin
        errors++;
        $display("FAIL fill_range_%0d: got %0d..%0d want %0d..%0d", k, disp_start, disp_end, k * 100, k * 100 + 7);
      end
    end
    @(negedge clk);
    checks++;
    if ({in_flight, slave_busy, vc_busy} !== {4'd4, 4'hF, 8'h0F}) begin
      errors++;
      $display("FAIL fill_state: got inflight=%0d slave=%h vc=%h want 4 f 0f", in_flight, slave_busy, vc_busy);
    end
  endtask

  task automatic test_stall;
    int seen;
    chunk_valid = 1'b1;
    chunk_id    = 9'd5;
    chunk_start = 32'd500;
    chunk_end   = 32'd507;
    seen        = 0;
    repeat (10) begin
      if (chunk_ready) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL stall_ready_low: got ready high %0d cycles want 0", seen);
    end
    done_pulse(2, 1);
    checks++;
    if ({chunk_ready, slave_busy, vc_busy} !== {1'b1, 4'hB, 8'h0D}) begin
      errors++;
      $display("FAIL stall_release: got ready=%b slave=%h vc=%h want 1 b 0d", chunk_ready, slave_busy, vc_busy);
    end
    @(posedge clk);
    #1;
    chunk_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({disp_valid, disp_slave, disp_vc, disp_id, in_flight} !== {1'b1, 2'd2, 3'd1, 9'd5, 4'd4}) begin
      errors++;
      $display("FAIL stall_disp: got v=%b s=%0d vc=%0d id=%0d inflight=%0d want 1 2 1 5 4",
               disp_valid, disp_slave, disp_vc, disp_id, in_flight);
    end
    @(negedge clk);
  endtask

  task automatic test_hold;
    int w;
    int bad;
    done_pulse(1, 3);
    done_pulse(3, 2);
    disp_ready = 1'b0;
    offer(10, w);
    @(negedge clk);
    checks++;
    if ({w > 0, disp_valid, disp_slave, disp_vc, disp_id} !== {1'b1, 1'b1, 2'd1, 3'd2, 9'd10}) begin
      errors++;
      $display("FAIL hold_alloc: got w=%0d v=%b s=%0d vc=%0d id=%0d want v=1 s=1 vc=2 id=10",
               w, disp_valid, disp_slave, disp_vc, disp_id);
    end
    chunk_valid = 1'b1;
    chunk_id    = 9'd11;
    bad         = 0;
    repeat (5) begin
      @(negedge clk);
      if ({disp_valid, chunk_ready, disp_slave, disp_vc, disp_id, disp_start, disp_end} !==
          {1'b1, 1'b0, 2'd1, 3'd2, 9'd10, 32'd1000, 32'd1007}) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
    end
    chunk_valid = 1'b0;
    disp_ready  = 1'b1;
    @(negedge clk);
    checks++;
    if ({disp_valid, in_flight, slave_busy, vc_busy} !== {1'b0, 4'd3, 4'h7, 8'h07}) begin
      errors++;
      $display("FAIL hold_release: got v=%b inflight=%0d slave=%h vc=%h want 0 3 7 07",
               disp_valid, in_flight, slave_busy, vc_busy);
    end
  endtask

  task automatic test_same_cycle;
    int w;
    chunk_valid = 1'b1;
    chunk_id    = 9'd6;
    chunk_start = 32'd600;
    chunk_end   = 32'd607;
    done_valid  = 1'b1;
    done_slave  = 2'd0;
    done_vc     = 3'd0;
    #1;
    checks++;
    if (chunk_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_ready: got %b want 1", chunk_ready);
    end
    @(posedge clk);
    #1;
    chunk_valid = 1'b0;
    done_valid  = 1'b0;
    @(negedge clk);
    checks++;
    if ({disp_slave, disp_vc, disp_id, in_flight, slave_busy, vc_busy} !==
        {2'd3, 3'd3, 9'd6, 4'd3, 4'hE, 8'h0E}) begin
      errors++;
      $display("FAIL same_both: got s=%0d vc=%0d id=%0d inflight=%0d slave=%h vc=%h want 3 3 6 3 e 0e",
               disp_slave, disp_vc, disp_id, in_flight, slave_busy, vc_busy);
    end
    offer(7, w);
    @(negedge clk);
    checks++;
    if ({w == 1, disp_slave, disp_vc, disp_id, in_flight} !== {1'b1, 2'd0, 3'd0, 9'd7, 4'd4}) begin
      errors++;
      $display("FAIL same_reuse: got w=%0d s=%0d vc=%0d id=%0d inflight=%0d want 1 0 0 7 4",
               w, disp_slave, disp_vc, disp_id, in_flight);
    end
    @(negedge clk);
  endtask

  task automatic test_double_free;
    checks++;
    if (err_double_free !== 1'b0) begin
      errors++;
      $display("FAIL dbl_clean: got %b want 0", err_double_free);
    end
    done_pulse(3, 3);
    checks++;
    if ({err_double_free, in_flight} !== {1'b0, 4'd3}) begin
      errors++;
      $display("FAIL dbl_legit: got err=%b inflight=%0d want 0 3", err_double_free, in_flight);
    end
    done_pulse(3, 3);
    checks++;
    if ({err_double_free, in_flight, slave_busy, vc_busy} !== {1'b1, 4'd3, 4'h7, 8'h07}) begin
      errors++;
      $display("FAIL dbl_flag: got err=%b inflight=%0d slave=%h vc=%h want 1 3 7 07",
               err_double_free, in_flight, slave_busy, vc_busy);
    end
    repeat (5) @(negedge clk);
    done_pulse(0, 0);
    checks++;
    if ({err_double_free, in_flight} !== {1'b1, 4'd2}) begin
      errors++;
      $display("FAIL dbl_sticky: got err=%b inflight=%0d want 1 2", err_double_free, in_flight);
    end
  endtask

`ifdef CHUNK_DISPATCH_RR_EN
  task automatic test_rr;
    int w;
    int exp_s [4] = '{1, 2, 3, 0};
    disp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      offer(31 + k, w);
      @(negedge clk);
      checks++;
      if ({w > 0, disp_slave, disp_vc} !== {1'b1, 2'(exp_s[k]), 3'(k)}) begin
        errors++;
        $display("FAIL rr_seq_%0d: got w=%0d s=%0d vc=%0d want s=%0d vc=%0d", k, w, disp_slave, disp_vc, exp_s[k], k);
      end
    end
    @(negedge clk);
    done_pulse(1, 0);
    offer(35, w);
    @(negedge clk);
    checks++;
    if ({w > 0, disp_slave} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL rr_last1: got w=%0d s=%0d want s=1", w, disp_slave);
    end
    @(negedge clk);
    done_pulse(0, 3);
    done_pulse(3, 2);
    offer(36, w);
    @(negedge clk);
    checks++;
    if ({w > 0, disp_slave, disp_vc} !== {1'b1, 2'd3, 3'd2}) begin
      errors++;
      $display("FAIL rr_skip: got w=%0d s=%0d vc=%0d want s=3 vc=2", w, disp_slave, disp_vc);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_issue;
    int w;
    disp_ready = 1'b0;
    offer(20, w);
    @(negedge clk);
    checks++;
    if ({w > 0, disp_valid, disp_id} !== {1'b1, 1'b1, 9'd20}) begin
      errors++;
      $display("FAIL rst_pre: got w=%0d v=%b id=%0d want v=1 id=20", w, disp_valid, disp_id);
    end
    chunk_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({disp_valid, chunk_ready, slave_busy, vc_busy, in_flight, err_double_free, disp_id} !== 28'd0) begin
      errors++;
      $display("FAIL rst_mid: got v=%b r=%b slave=%h vc=%h inflight=%0d err=%b id=%0d want all 0",
               disp_valid, chunk_ready, slave_busy, vc_busy, in_flight, err_double_free, disp_id);
    end
    chunk_valid = 1'b0;
    @(negedge clk);
    rst        = 1'b1;
    disp_ready = 1'b1;
    offer(21, w);
    @(negedge clk);
    checks++;
`ifdef CHUNK_DISPATCH_RR_EN
    if ({w > 0, disp_slave, disp_vc, disp_id, in_flight} !== {1'b1, 2'd1, 3'd0, 9'd21, 4'd1}) begin
`else
    if ({w > 0, disp_slave, disp_vc, disp_id, in_flight} !== {1'b1, 2'd0, 3'd0, 9'd21, 4'd1}) begin
`endif
      errors++;
      $display("FAIL rst_after: got w=%0d s=%0d vc=%0d id=%0d inflight=%0d want fresh alloc id=21 inflight=1",
               w, disp_slave, disp_vc, disp_id, in_flight);
    end
  endtask

  initial begin
    rst         = 1'b0;
    chunk_valid = 1'b0;
    chunk_id    = '0;
    chunk_start = '0;
    chunk_end   = '0;
    disp_ready  = 1'b1;
    done_valid  = 1'b0;
    done_slave  = '0;
    done_vc     = '0;
    test_reset;
`ifdef CHUNK_DISPATCH_RR_EN
    test_rr;
`else
    test_fill;
    test_stall;
    test_hold;
    test_same_cycle;
    test_double_free;
`endif
    test_reset_mid_issue;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
